// File: rtl/status_serial_tx_if.sv
// Load handshake between a status-word producer and the serial transmitter.
interface status_serial_tx_if #(
  parameter int WIDTH = 9
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] status_in;

  modport master (
    output load_valid,
    output status_in,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  status_in,
    output load_ready
  );
endinterface

// File: rtl/status_serial_tx.sv
// Framed parallel-to-serial transmitter: start, WIDTH data bits LSB first,
// parity, stop; each bit held DIV sysclk cycles. All outputs are registered.
module status_serial_tx #(
  parameter int WIDTH      = 9,
  parameter int DIV        = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                sysclk,
  input  logic                reset,
  status_serial_tx_if.slave   load,
  output logic                sout,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic             ODD      = (PARITY_ODD != 0);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             bit_end;

  assign bit_end = (div_cnt == DIV_LAST);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      shreg           <= '0;
      par             <= 1'b0;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      sout            <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      load.load_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // load_ready is high throughout IDLE, so valid alone means accept
          if (load.load_valid) begin
            shreg           <= load.status_in;
            par             <= (^load.status_in) ^ ODD;
            div_cnt         <= '0;
            bit_cnt         <= '0;
            sout            <= 1'b0;
            busy            <= 1'b1;
            load.load_ready <= 1'b0;
            state           <= START;
          end
        end
        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sout    <= shreg[0];
            shreg   <= shreg >> 1;
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              sout  <= par;
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sout    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            div_cnt <= '0;
            sout    <= 1'b1;
            state   <= STOP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt         <= '0;
            busy            <= 1'b0;
            done            <= 1'b1;
            load.load_ready <= 1'b1;
            state           <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          sout            <= 1'b1;
          busy            <= 1'b0;
          load.load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_serial_tx.sv
// Two transmitters (DIV=4 even, DIV=1 odd) checked cycle by cycle against
// a frame-level reference model through per-instance expectation queues.
module tb_status_serial_tx;

  typedef struct packed {
    logic sout;
    logic busy;
    logic done;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] lv = '0;
  logic [8:0] si [2];
  logic [1:0] sout_v, busy_v, done_v, rdy_v;
  logic [1:0] cur_ready = 2'b11;
  int         acc_cnt [2];
  ent_t       q0 [$];
  ent_t       q1 [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  status_serial_tx_if #(.WIDTH(9)) ifa ();
  status_serial_tx_if #(.WIDTH(9)) ifb ();

  assign ifa.load_valid = lv[0];
  assign ifa.status_in  = si[0];
  assign ifb.load_valid = lv[1];
  assign ifb.status_in  = si[1];
  assign rdy_v[0] = ifa.load_ready;
  assign rdy_v[1] = ifb.load_ready;

  status_serial_tx #(.WIDTH(9), .DIV(4), .PARITY_ODD(0)) dut0 (
    .sysclk (clk),
    .reset  (reset),
    .load   (ifa),
    .sout   (sout_v[0]),
    .busy   (busy_v[0]),
    .done   (done_v[0])
  );

  status_serial_tx #(.WIDTH(9), .DIV(1), .PARITY_ODD(1)) dut1 (
    .sysclk (clk),
    .reset  (reset),
    .load   (ifb),
    .sout   (sout_v[1]),
    .busy   (busy_v[1]),
    .done   (done_v[1])
  );

  task automatic chk(input string name, input int i, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got %b want %b", name, i, $time, act, exp);
    end
  endtask

  // Reference: frame = start 0, data LSB first, parity, stop 1, each bit
  // DIV cycles with busy high, then one idle cycle carrying done.
  function automatic void push_frame(input int i, input logic [8:0] w);
    int   d;
    logic odd;
    logic par;
    logic bits [$];
    ent_t e;
    d   = (i == 0) ? 4 : 1;
    odd = (i == 1);
    par = logic'($countones(w) % 2) ^ odd;
    bits.push_back(1'b0);
    for (int k = 0; k < 9; k++) bits.push_back(w[k]);
    bits.push_back(par);
    bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int r = 0; r < d; r++) begin
        e.sout = bits[b]; e.busy = 1'b1; e.done = 1'b0;
        if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    e.sout = 1'b1; e.busy = 1'b0; e.done = 1'b1;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (lv[i] && cur_ready[i]) begin
          push_frame(i, si[i]);
          acc_cnt[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      ent_t e;
      logic have;
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (i == 0) ? q0.pop_front() : q1.pop_front();
      else begin e.sout = 1'b1; e.busy = 1'b0; e.done = 1'b0; end
      chk("sout", i, sout_v[i], e.sout);
      chk("busy", i, busy_v[i], e.busy);
      chk("done", i, done_v[i], e.done);
      chk("load_ready", i, rdy_v[i], !have || e.done);
      cur_ready[i] = !have || e.done;
    end
  end

  task automatic send(input int i, input logic [8:0] w);
    int n0;
    n0 = acc_cnt[i];
    lv[i] = 1'b1;
    si[i] = w;
    for (int c = 0; c < 200 && acc_cnt[i] == n0; c++) begin
      @(posedge clk); #1;
    end
    lv[i] = 1'b0;
    chk("accept_timeout", i, logic'(acc_cnt[i] != n0), 1'b1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 500 && (q0.size() != 0 || q1.size() != 0); c++) @(posedge clk);
    chk("drain_timeout", 0, logic'(q0.size() == 0 && q1.size() == 0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    si[0] = '0;
    si[1] = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    chk("reset_sout", 0, sout_v[0], 1'b1);
    chk("reset_ready", 1, rdy_v[1], 1'b1);

    send(0, 9'h1A5);
    wait_idle();

    send(0, 9'h0F0);
    repeat (9) @(posedge clk);
    #1 lv[0] = 1'b1; si[0] = 9'h155;
    @(posedge clk);
    #1 lv[0] = 1'b0;
    wait_idle();

    n0 = acc_cnt[0];
    lv[0] = 1'b1; si[0] = 9'h000;
    for (int c = 0; c < 300 && acc_cnt[0] < n0 + 2; c++) begin
      @(posedge clk); #1;
    end
    lv[0] = 1'b0;
    chk("b2b_accepts", 0, logic'(acc_cnt[0] == n0 + 2), 1'b1);
    wait_idle();

    send(0, 9'h1A5);
    repeat (17) @(posedge clk);
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_sout", 0, sout_v[0], 1'b1);
    chk("rst_busy", 0, busy_v[0], 1'b0);
    chk("rst_ready", 0, rdy_v[0], 1'b1);
    chk("rst_done", 0, done_v[0], 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    send(0, 9'h001);
    wait_idle();

    send(1, 9'h1FF);
    wait_idle();

    send(0, 9'h0A3);
    send(1, 9'h0A3);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      si[0] = 9'($urandom);
      si[1] = 9'($urandom);
    end
    wait_idle();

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      lv[0] = ($urandom_range(0, 3) == 0);
      lv[1] = ($urandom_range(0, 2) == 0);
      si[0] = 9'($urandom);
      si[1] = 9'($urandom);
    end
    lv = '0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
